// File: rtl/pu_sequencer_pkg.sv
// Shared types and constants for the processing-unit sequencer.
// State encoding, default latency and FP32 reference values.
package pu_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seqState_t;

  localparam int DEF_PU_LATENCY = 3;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO  = 32'h4000_0000;

endpackage

// File: rtl/pu_sequencer_tag_pipe.sv
// Valid+index delay line that mirrors the processing-unit latency.
// Shifts every cycle; async reset discards all in-flight tags.
module pu_sequencer_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inValid,
  input  logic [W-1:0] inIdx,
  output logic         outValid,
  output logic [W-1:0] outIdx
);

  logic         vld [DEPTH];
  logic [W-1:0] idx [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i] <= 1'b0;
        idx[i] <= '0;
      end
    end else begin
      vld[0] <= inValid;
      idx[0] <= inIdx;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign outValid = vld[DEPTH-1];
  assign outIdx   = idx[DEPTH-1];

endmodule

// File: rtl/pu_sequencer.sv
// Operand-side sequencer: issues one neuron per cycle to the PU
// and writes the returned results to result memory in order.
module pu_sequencer
  import pu_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PU_LATENCY = DEF_PU_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_neurons,
  output logic [ADDR_W-1:0] w_addr,
  output logic              pu_en,
  input  logic [31:0]       pu_result,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [31:0]       res_data,
  output logic              busy,
  output logic              done
);

  seqState_t state, nextState;

  logic [ADDR_W-1:0] nCap;
  logic [ADDR_W-1:0] issueCnt;
  logic [ADDR_W-1:0] lastIdx;
  logic              lastIssue;
  logic              lastWrite;
  logic              accept;

  assign lastIdx   = nCap - ADDR_W'(1);
  assign lastIssue = (issueCnt == lastIdx);
  assign lastWrite = res_we && (res_addr == lastIdx);
  assign accept    = (state == IDLE) && start
                     && (num_neurons != '0);

  assign w_addr   = issueCnt;
  assign res_data = pu_result;

  // Counter stops at N-1 so it holds in DRAIN and never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      nCap     <= '0;
      issueCnt <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        nCap     <= num_neurons;
        issueCnt <= '0;
      end else if (state == ISSUE && !lastIssue) begin
        issueCnt <= issueCnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    nextState = state;
    pu_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nextState = (num_neurons != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        pu_en = 1'b1;
        busy  = 1'b1;
        if (lastIssue) nextState = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (lastWrite) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  pu_sequencer_tag_pipe #(
    .DEPTH(PU_LATENCY),
    .W    (ADDR_W)
  ) uTagPipe (
    .clk     (clk),
    .rst_n   (rst),
    .inValid (pu_en),
    .inIdx   (w_addr),
    .outValid(res_we),
    .outIdx  (res_addr)
  );

endmodule

// File: tb/tb_pu_sequencer.sv
// Bench for pu_sequencer: behavioural PU plus a per-cycle
// timeline model of each layer run.
module tb_pu_sequencer;
  import pu_sequencer_pkg::*;

  localparam int AW = 8;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_neurons;
  logic [AW-1:0] w_addr;
  logic          pu_en;
  logic [31:0]   pu_result = 32'h0;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [31:0]   res_data;
  logic          busy;
  logic          done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] valueOf [256];

  typedef struct {
    int due;
    int idx;
  } ev_t;
  ev_t pend[$];

  pu_sequencer #(
    .ADDR_W    (AW),
    .PU_LATENCY(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_neurons(num_neurons),
    .w_addr     (w_addr),
    .pu_en      (pu_en),
    .pu_result  (pu_result),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_data   (res_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Behavioural PU: value for the issued neuron appears L cycles later.
  always @(posedge clk) begin
    if (!rst) pend.delete();
    else if (pu_en) pend.push_back('{cyc + L, int'(w_addr)});
    cyc++;
    pu_result = $urandom;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      pu_result = valueOf[pend[0].idx];
      void'(pend.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, ".pu_en"}, 32'(pu_en), 32'd0);
    chk({tag, ".res_we"}, 32'(res_we), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  // Layer of n neurons: issue in cycles 1..n, writes in 1+L..n+L,
  // done at n+L+1 (or cycle 1 when n=0).
  task automatic runLayer(input int n, input bit reIssue,
                          input bit reDrain);
    bit eEn, eWe, eBusy, eDone;
    @(negedge clk);
    start       = 1'b1;
    num_neurons = AW'(n);
    for (int j = 1; j <= n + L + 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      eEn   = (n > 0) && (j <= n);
      eWe   = (n > 0) && (j >= 1 + L) && (j <= n + L);
      eBusy = (n > 0) && (j <= n + L);
      eDone = (n == 0) ? (j == 1) : (j == n + L + 1);
      chk($sformatf("n%0d.c%0d.pu_en", n, j), 32'(pu_en), 32'(eEn));
      chk($sformatf("n%0d.c%0d.res_we", n, j), 32'(res_we), 32'(eWe));
      chk($sformatf("n%0d.c%0d.busy", n, j), 32'(busy), 32'(eBusy));
      chk($sformatf("n%0d.c%0d.done", n, j), 32'(done), 32'(eDone));
      if (eEn)
        chk($sformatf("n%0d.c%0d.w_addr", n, j), 32'(w_addr), j - 1);
      if (eWe) begin
        chk($sformatf("n%0d.c%0d.res_addr", n, j), 32'(res_addr),
            j - 1 - L);
        chk($sformatf("n%0d.c%0d.res_data", n, j), res_data,
            valueOf[j-1-L]);
      end
      if ((reIssue && j == 2) || (reDrain && j == n + 1)) begin
        start       = 1'b1;
        num_neurons = AW'(9);
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    num_neurons = '0;
    for (int i = 0; i < 256; i++) valueOf[i] = FP_ZERO;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkIdle("reset");
    chk("reset.w_addr", 32'(w_addr), 32'd0);
    chk("reset.res_addr", 32'(res_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chkIdle("postrst");

    // 1.0 * 2.0 summed over four inputs = 8.0
    for (int i = 0; i < 4; i++) valueOf[i] = 32'h4100_0000;
    runLayer(4, 1'b0, 1'b0);

    // Neuron 1 sums to -8.0; ReLU upstream yields zero
    valueOf[0] = 32'h4100_0000;
    valueOf[1] = FP_ZERO;
    valueOf[2] = 32'h4100_0000;
    runLayer(3, 1'b0, 1'b0);

    runLayer(0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) valueOf[i] = $urandom;
    runLayer(6, 1'b1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) valueOf[i] = $urandom;
      runLayer(n, 1'($urandom), 1'($urandom));
    end

    runLayer(1, 1'b0, 1'b1);

    // Async reset after three issues of an 8-neuron layer
    @(negedge clk);
    start       = 1'b1;
    num_neurons = AW'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chkIdle("midrst");
    chk("midrst.w_addr", 32'(w_addr), 32'd0);
    chk("midrst.res_addr", 32'(res_addr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chkIdle($sformatf("afterrst.c%0d", j));
    end
    valueOf[0] = $urandom;
    valueOf[1] = $urandom;
    runLayer(2, 1'b0, 1'b0);

    for (int i = 0; i < 255; i++) valueOf[i] = $urandom;
    runLayer(255, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pu_sequencer.md
Name: pu_sequencer

Overview:
- Initiator/controller on the operand side of the 4-input processing unit, which computes ReLU(A1·W1+A2·W2+A3·W3+A4·W4) in IEEE-754 single precision.
- Steps through a layer of neurons, one neuron per cycle. For each neuron it drives the weight-memory address and the processing unit's register-stage enable.
- Tracks each in-flight neuron through the unit's fixed pipeline and writes every returned result to result memory, in order.
- Sits between the weight ROM / result RAM and one processing unit inside the layer datapath.

Parameters:
- ADDR_W, 8, width of neuron index, weight address and result address.
- PU_LATENCY, 3, cycles from the pu_en-high cycle to the matching value on pu_result (1 register stage + 2 adder levels); legal 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request to process a layer; sampled only in IDLE.
- num_neurons  in  ADDR_W  neuron count for the layer; captured on accepted start.
- w_addr  out  ADDR_W  weight-memory address (combinational-read ROM returns W1..W4 for neuron w_addr in the same cycle).
- pu_en  out  1  processing-unit register-stage enable.
- pu_result  in  32  processing-unit output.
- res_we  out  1  result-memory write enable.
- res_addr  out  ADDR_W  result-memory write address.
- res_data  out  32  result-memory write data; combinational pass of pu_result.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last result write.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; w_addr=0, pu_en=0, res_we=0, res_addr=0, busy=0, done=0; tag pipeline cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and num_neurons>0: capture N, issue_cnt=0, go to ISSUE.
  - start=1 and num_neurons=0: go to DONE directly; no pu_en, no res_we.
- ISSUE:
  - pu_en=1, w_addr=issue_cnt; issue_cnt increments each cycle.
  - When issue_cnt=N-1 in a cycle, go to DRAIN next.
  - Neuron k is issued in cycle 1+k after the start-sampling edge.
- DRAIN:
  - pu_en=0, w_addr holds its last value.
  - Leave for DONE in the cycle after the last res_we.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Tag pipeline:
  - PU_LATENCY-deep shift register of {valid, index}; shifts every cycle regardless of state.
  - Input is {pu_en, w_addr}.
  - res_we = output valid; res_addr = output index.
  - Net effect: res_we for neuron k is asserted in cycle 1+k+PU_LATENCY, in the same cycle pu_result carries neuron k's value.
- Results are written in strictly increasing address order, one per cycle, with no gaps. No backpressure: result memory must accept every cycle.
- start while busy (ISSUE/DRAIN/DONE): ignored; num_neurons changes after capture have no effect.
- N=2^ADDR_W-1: the counter must not wrap before the final issue; compare uses the captured N.
- Reset mid-operation: in-flight tags are discarded; no res_we after reset release until a new start.
- No arithmetic in this block; it never alters pu_result (ReLU is already applied upstream).

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/DRAIN/DONE), default PU_LATENCY, FP32 constants for benches (ONE=0x3F800000, TWO=0x40000000, ZERO).
- One sub-module: tag_pipe (parameterised depth/width valid+index shift register, async active-low reset).

Test Plan:
- N=4, A=1.0, all weights 2.0 (0x40000000): pu_en high in cycles 1-4; res_we in cycles 4-7 with res_addr 0..3, res_data 0x41000000 each; done pulse in cycle 8; busy high cycles 1-7.
- N=3, neuron 1 weights -2.0 (0xC0000000): res_data at addr 1 = 0x00000000, addrs 0 and 2 = 0x41000000.
- num_neurons=0 with start: done pulses on the next cycle; pu_en and res_we never assert.
- start re-pulsed during ISSUE and during DRAIN with num_neurons=9: ignored; exactly the original N writes; one done.
- rst=0 asserted asynchronously mid-ISSUE of N=8 (after 3 issues): all outputs 0 immediately; no res_we after release; a new start with N=2 yields writes to addr 0 and 1 only.
- N=255, ADDR_W=8: 255 writes at addresses 0..254 in order, no wrap to 0, one done.
